// File: rtl/bus_pkg.sv
// Shared definitions for the single-wire serial bus.
// Used by both ends of the link: the parallel_serial transmitter and the
// serial_parallel receiver.
//   - default widths for the parallel word and the length field
//   - line levels for the start bit and the idle line
//   - encoding of the receiver's two states
package bus_pkg;

  localparam int unsigned DefParallelPortWidth = 14;
  localparam int unsigned DefBitLength         = 4;

  localparam logic StartLevel = 1'b1;
  localparam logic IdleLevel  = 1'b0;

  localparam logic IDLE = 1'b0;
  localparam logic RECV = 1'b1;

  typedef enum logic {
    StIdle = IDLE,
    StRecv = RECV
  } rx_state_e;

endpackage

// File: rtl/serial_parallel.sv
// Receiving end of the single-wire serial link.
// Waits for a start bit, then shifts in bit_lngt data bits, MSB first, one per
// clock. It then presents the assembled word right-aligned on dout, together
// with a one-cycle dv_out pulse.
// Ports:
//   clk      - system clock, rising-edge sampling
//   rstn     - asynchronous active-low reset
//   din      - serial line, idles low
//   bit_lngt - payload length of the next frame, sampled only on the start bit
//   dout     - last received word, upper unused bits zero
//   dv_out   - one-cycle pulse when dout has just been updated
//   busy     - high while a frame is being received
//   err      - one-cycle pulse when a start bit arrives with an invalid length
module serial_parallel
  import bus_pkg::*;
#(
  parameter int unsigned PARALLEL_PORT_WIDTH = DefParallelPortWidth,
  parameter int unsigned BIT_LENGTH          = DefBitLength
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           din,
  input  logic [BIT_LENGTH-1:0]          bit_lngt,
  output logic [PARALLEL_PORT_WIDTH-1:0] dout,
  output logic                           dv_out,
  output logic                           busy,
  output logic                           err
);

  localparam int unsigned PW = PARALLEL_PORT_WIDTH;

  // One bit wider than bit_lngt, so the upper-bound compare cannot truncate.
  localparam logic [BIT_LENGTH:0] MaxLen = (BIT_LENGTH + 1)'(PW);

  rx_state_e             state_q;
  logic [PW-2:0]         shreg_q;  // the final bit is appended straight into dout
  logic [BIT_LENGTH-1:0] cnt_q;
  logic [BIT_LENGTH-1:0] len_q;

  logic                  len_ok;
  logic [BIT_LENGTH-1:0] cnt_inc;

  always_comb begin
    len_ok  = (bit_lngt != '0) && ({1'b0, bit_lngt} <= MaxLen);
    cnt_inc = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      dout    <= '0;
      dv_out  <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      dv_out <= 1'b0;
      err    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (din == StartLevel) begin
            if (len_ok) begin
              len_q   <= bit_lngt;
              shreg_q <= '0;
              cnt_q   <= '0;
              busy    <= 1'b1;
              state_q <= StRecv;
            end else begin
              err <= 1'b1;
            end
          end
        end
        StRecv: begin
          // The register is cleared on the start bit, so the bits above N stay zero.
          shreg_q <= {shreg_q[PW-3:0], din};
          cnt_q   <= cnt_inc;
          if (cnt_inc == len_q) begin
            dout    <= {shreg_q, din};
            dv_out  <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

endmodule
